// File: rtl/magnetron_sr_driver.sv
// ---------------------------------------------------------------------------
// magnetron_sr_driver: mutually exclusive set/reset pulse driver for the magnetron SR latch; MAG_SYNC_EN adds input synchronizers.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module magnetron_sr_driver #(
  parameter int PULSE_CYCLES = 3,
  parameter int GUARD_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic stop,
  input  logic door_closed,
  input  logic timer_done,
  output logic set,
  output logic reset,
  output logic mag_on,
  output logic busy
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_OFF   = 3'd1,
    S_PSET  = 3'd2,
    S_ON    = 3'd3,
    S_PRST  = 3'd4,
    S_GUARD = 3'd5
  } state_t;

  logic start_s;
  logic stop_s;
  logic door_s;
  logic timer_s;

`ifdef MAG_SYNC_EN
  logic [1:0] start_ff;
  logic [1:0] stop_ff;
  logic [1:0] door_ff;
  logic [1:0] timer_ff;

  // Door synchronizer resets to 0, so the interlock reads "open" until it fills.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_ff <= 2'b00;
      stop_ff  <= 2'b00;
      door_ff  <= 2'b00;
      timer_ff <= 2'b00;
    end else begin
      start_ff <= {start_ff[0], start};
      stop_ff  <= {stop_ff[0], stop};
      door_ff  <= {door_ff[0], door_closed};
      timer_ff <= {timer_ff[0], timer_done};
    end
  end

  assign start_s = start_ff[1];
  assign stop_s  = stop_ff[1];
  assign door_s  = door_ff[1];
  assign timer_s = timer_ff[1];
`else
  assign start_s = start;
  assign stop_s  = stop;
  assign door_s  = door_closed;
  assign timer_s = timer_done;
`endif

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             pend;
  logic             pend_nx;
  logic             mag_nx;
  logic             start_q;
  logic             stop_q;
  logic             start_rise;
  logic             stop_rise;
  logic             off_req;
  logic             pulse_last;
  logic             guard_last;

  assign start_rise = start_s & ~start_q;
  assign stop_rise  = stop_s & ~stop_q;
  assign off_req    = stop_rise | ~door_s | timer_s;
  assign pulse_last = (cnt == CNT_W'(PULSE_CYCLES - 1));
  assign guard_last = (cnt == CNT_W'(GUARD_CYCLES - 1));

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    pend_nx  = pend;
    mag_nx   = mag_on;
    case (state)
      S_INIT: state_nx = S_PRST;
      S_OFF: begin
        if (start_rise && door_s && !timer_s && !stop_rise) state_nx = S_PSET;
      end
      S_PSET: begin
        cnt_nx  = cnt + CNT_W'(1);
        pend_nx = pend | off_req;
        if (pulse_last) begin
          state_nx = S_GUARD;
          mag_nx   = 1'b1;
        end
      end
      S_ON: begin
        if (off_req) state_nx = S_PRST;
      end
      S_PRST: begin
        cnt_nx = cnt + CNT_W'(1);
        if (pulse_last) begin
          state_nx = S_GUARD;
          mag_nx   = 1'b0;
        end
      end
      S_GUARD: begin
        cnt_nx = cnt + CNT_W'(1);
        // Only a guard following a set pulse can owe an off; after a reset pulse the latch is already off.
        pend_nx = pend | (mag_on & off_req);
        if (guard_last) state_nx = pend_nx ? S_PRST : (mag_on ? S_ON : S_OFF);
      end
      default: state_nx = S_INIT;
    endcase
    if (state_nx != state) cnt_nx = '0;
    if (state_nx == S_PRST && state != S_PRST) pend_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_INIT;
      cnt     <= '0;
      pend    <= 1'b0;
      mag_on  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      set     <= 1'b0;
      reset   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend    <= pend_nx;
      mag_on  <= mag_nx;
      start_q <= start_s;
      stop_q  <= stop_s;
      // Outputs decode the next state so they are true flops and can never overlap.
      set     <= (state_nx == S_PSET);
      reset   <= (state_nx == S_PRST);
      busy    <= (state_nx != S_OFF) && (state_nx != S_ON);
    end
  end

endmodule

`default_nettype wire
